vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Shares one single-port synchronous framebuffer RAM between VGA scan-out and a pixel writer.
//  Consumes the free-running 800x525 x/y scan counter (pixel clock domain, same clk).
//  Produces the registered pixel stream and the hsync/vsync signals.
//  Display reads have absolute priority. Writer requests are buffered in a small FIFO.
//  The FIFO drains into every memory cycle the display does not need.
// PARAMETERS
//  DW          12      pixel width (RGB444)
//  AW          19      memory address width
//  FIFO_DEPTH  4       writer FIFO entries (power of 2, >=2)
//  RD_LAT      1       RAM read latency in clocks (1 or 2)
//  BLANK_COLOR 0       pix_data value outside the active area
// PORTS
//  clk        in   1    pixel clock (25 MHz)
//  rst        in   1    asynchronous reset, active-low
//  x          in   10   scan column 0..799, from counter
//  y          in   10   scan row 0..524, from counter
//  wr_valid   in   1    writer request
//  wr_ready   out  1    FIFO not full; transfer when wr_valid&wr_ready at posedge
//  wr_addr    in   AW   linear framebuffer address
//  wr_data    in   DW   pixel to write
//  mem_addr   out  AW   RAM address (registered)
//  mem_we     out  1    RAM write enable (registered)
//  mem_wdata  out  DW   RAM write data (registered)
//  mem_rdata  in   DW   RAM read data, valid RD_LAT clocks after mem_addr
//  pix_data   out  DW   pixel to DAC (registered)
//  pix_active out  1    1 inside 640x480 active area (registered)
//  hsync      out  1    active-low, asserted for x 656..751
//  vsync      out  1    active-low, asserted for y 490..491
// BEHAVIOUR
//  - Reset: mem_addr=0, mem_we=0, mem_wdata=0, pix_data=0, pix_active=0, hsync=1, vsync=1.
//    Reset empties the FIFO; wr_ready=1 from the first clock after release.
//    Reset asserted mid-frame or mid-write discards all queued writes; no partial RAM write is issued.
//  - Output alignment: pix_data, pix_active, hsync and vsync lag the counter by exactly 1 clk.
//    They reflect position (x,y) in the cycle after the counter shows (x,y).
//  - Fetch lead: L = RD_LAT+1 counter positions.
//    While the counter is at p, the slot for the next mem cycle is decided from position q = p+L.
//    q wraps: x+L>799 gives column x+L-800 of row y+1; row 524+1 wraps to row 0.
//  - Display slot: q is active (qx<640, qy<480).
//    Drive mem_we=0 and mem_addr = qy*640+qx, computed as (qy<<9)+(qy<<7)+qx, AW bits.
//  - Write slot: q is inactive and the FIFO is non-empty.
//    Pop the head entry; drive mem_we=1, mem_addr=entry addr, mem_wdata=entry data.
//  - Idle slot: mem_we=0; mem_addr holds its previous value.
//  - An entry with addr >= 307200 is popped in a write slot but issued with mem_we=0, i.e. dropped.
//  - pix_data = mem_rdata when the output position is active, else BLANK_COLOR.
//  - FIFO: wr_ready = !full, combinational from the count.
//    Push and pop in the same cycle leave the count unchanged. Pop only in write slots.
//    Order is strictly FIFO. A write and a read of the same address in adjacent slots need no coherence:
//    the read may return the old data.
// CONFIGURATION
//  FB_PIXEL_DOUBLE_EN defined:
//    - The framebuffer is 320x240; display address = (qy>>1)*320+(qx>>1).
//    - The display slot applies only when q is active and qx is even.
//      Odd active q slots are available to the writer.
//    - pix_data holds its value for odd columns. The write-range limit is 76800.
//  FB_PIXEL_DOUBLE_EN undefined:
//    - 640x480 as above; the writer gets only blanking slots.
// TESTING
//  1. Preload RAM with mem[a]=a[11:0]; run 1 frame.
//     -> pix_data at output (x,y) = (y*640+x)[11:0] for all active pixels; BLANK_COLOR elsewhere.
//  2. Counter at x=798,y=479 -> next mem cycle reads addr 307200? no: q row 480 inactive, so write slot.
//     Counter at x=798,y=524 -> mem_addr=0, mem_we=0 (row wrap to 0).
//  3. Push 5 writes at y=100 while FIFO_DEPTH=4 -> wr_ready=0 after 4.
//     Writes issue at the first blank slot, x=638 (q=640).
//     All 5 writes have landed by x=643, in push order.
//  4. Push wr_addr=307200 during blanking -> accepted, mem_we never 1 for it; wr_ready returns 1.
//  5. Assert rst at x=300,y=200 with 3 writes queued -> all outputs at reset values immediately.
//     After release no stale writes are issued.
//  6. FB_PIXEL_DOUBLE_EN, 3 writes queued at y=10 -> writes issue in odd-q slots at x=1,3,5.
//     pix_data is constant across each column pair.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// Writer request channel and single-port framebuffer RAM port of vga_fb_arbiter.
// The arbiter connects as slave; the writer/RAM environment connects as master.
interface vga_fb_arbiter_if #(
    parameter int unsigned DW = 12,
    parameter int unsigned AW = 19
);
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM between 640x480 VGA scan-out and a FIFO-buffered pixel writer.
// Define FB_PIXEL_DOUBLE_EN for a 320x240 framebuffer scanned out with 2x pixel doubling.
module vga_fb_arbiter #(
    parameter int unsigned    DW          = 12,
    parameter int unsigned    AW          = 19,
    parameter int unsigned    FIFO_DEPTH  = 4,
    parameter int unsigned    RD_LAT      = 1,
    parameter logic [DW-1:0]  BLANK_COLOR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    vga_fb_arbiter_if.slave      bus,
    output logic [DW-1:0]        pix_data,
    output logic                 pix_active,
    output logic                 hsync,
    output logic                 vsync
);

    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned H_ACT    = 640;
    localparam int unsigned V_ACT    = 480;
    localparam int unsigned HS_FIRST = 656;
    localparam int unsigned HS_LAST  = 751;
    localparam int unsigned VS_FIRST = 490;
    localparam int unsigned VS_LAST  = 491;
    localparam int unsigned LEAD     = RD_LAT + 1;
`ifdef FB_PIXEL_DOUBLE_EN
    localparam int unsigned FB_SIZE  = 76800;
`else
    localparam int unsigned FB_SIZE  = 307200;
`endif
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_entry_t;

    logic [10:0]      x_sum;
    logic             q_wrap;
    logic [9:0]       qx;
    logic [9:0]       qy;
    logic             q_active;
    logic             display_slot;
    logic [AW-1:0]    disp_addr;

    wr_entry_t        fifo_mem [FIFO_DEPTH];
    wr_entry_t        head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             in_range;

    logic             pos_active_c;
    logic             hsync_c;
    logic             vsync_c;

    // Fetch position q: LEAD positions ahead of the counter, wrapping column, row and frame.
    always_comb begin
        x_sum  = 11'(x) + 11'(LEAD);
        q_wrap = (x_sum >= 11'(H_TOTAL));
        qx     = q_wrap ? 10'(x_sum - 11'(H_TOTAL)) : x_sum[9:0];
        qy     = y;
        if (q_wrap) begin
            qy = (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
        end
        q_active = (qx < 10'(H_ACT)) && (qy < 10'(V_ACT));
`ifdef FB_PIXEL_DOUBLE_EN
        // Only even columns fetch; odd active slots go to the writer.
        display_slot = q_active && !qx[0];
        disp_addr    = (AW'(qy >> 1) << 8) + (AW'(qy >> 1) << 6) + AW'(qx >> 1);
`else
        display_slot = q_active;
        disp_addr    = (AW'(qy) << 9) + (AW'(qy) << 7) + AW'(qx);
`endif
    end

    assign bus.wr_ready = (count != CNT_W'(FIFO_DEPTH));
    assign fifo_empty   = (count == '0);
    assign push         = bus.wr_valid && bus.wr_ready;
    assign pop          = !display_slot && !fifo_empty;
    assign head         = fifo_mem[rd_ptr];
    assign in_range     = (head.addr < AW'(FB_SIZE));

    // Writer FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: bus.wr_addr, data: bus.wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // RAM port: display read, writer pop (out-of-range entries dropped), or idle hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= '0;
        end else if (display_slot) begin
            bus.mem_addr  <= disp_addr;
            bus.mem_we    <= 1'b0;
        end else if (pop) begin
            bus.mem_addr  <= head.addr;
            bus.mem_wdata <= head.data;
            bus.mem_we    <= in_range;
        end else begin
            bus.mem_we    <= 1'b0;
        end
    end

    assign pos_active_c = (x < 10'(H_ACT)) && (y < 10'(V_ACT));
    assign hsync_c      = !((x >= 10'(HS_FIRST)) && (x <= 10'(HS_LAST)));
    assign vsync_c      = !((y >= 10'(VS_FIRST)) && (y <= 10'(VS_LAST)));

    // Read data for the current counter position arrives now; register it with the sync pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_data   <= '0;
            pix_active <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
        end else begin
            pix_active <= pos_active_c;
            hsync      <= hsync_c;
            vsync      <= vsync_c;
`ifdef FB_PIXEL_DOUBLE_EN
            pix_data   <= pos_active_c ? (x[0] ? pix_data : bus.mem_rdata) : BLANK_COLOR;
`else
            pix_data   <= pos_active_c ? bus.mem_rdata : BLANK_COLOR;
`endif
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: position vector table, scan-row sweeps and writer/reset sequences.
module tb_vga_fb_arbiter;
    localparam int unsigned DW = 12;
    localparam int unsigned AW = 19;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned RD_LAT = 1;

`ifdef FB_PIXEL_DOUBLE_EN
    localparam logic [11:0] P_0_0 = 12'h000, P_1_0 = 12'h000, P_639_0 = 12'h13F;
    localparam logic [11:0] P_0_1 = 12'h000, P_100 = 12'hEB2, P_LAST  = 12'hBFF;
    localparam logic [AW-1:0] HOLD_ADDR = 19'd16050;
`else
    localparam logic [11:0] P_0_0 = 12'h000, P_1_0 = 12'h001, P_639_0 = 12'h27F;
    localparam logic [11:0] P_0_1 = 12'h280, P_100 = 12'hA64, P_LAST  = 12'hFFF;
    localparam logic [AW-1:0] HOLD_ADDR = 19'd64101;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [DW-1:0] pix_data;
    logic          pix_active;
    logic          hsync;
    logic          vsync;

    vga_fb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    vga_fb_arbiter #(
        .DW(DW), .AW(AW), .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT), .BLANK_COLOR(12'h000)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .bus(bus.slave),
        .pix_data(pix_data), .pix_active(pix_active), .hsync(hsync), .vsync(vsync)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM model with RD_LAT-cycle read pipeline.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= ram[bus.mem_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
    end
    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    typedef struct {
        int          px;
        int          py;
        logic        act;
        logic        hs;
        logic        vs;
        logic [11:0] pix;
    } vec_t;

    vec_t          vecs [16];
    int            total = 0;
    int            bad = 0;
    int            prev_x;
    int            prev_y;
    int            k;
    int            nwe;
    int            found;
    logic          acc;
    logic [11:0]   pa;
    int            dq [$];
    logic [AW-1:0] oa [$];
    logic [DW-1:0] od [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // One clock: sample point is 1 time unit after the edge, then the counter advances.
    task automatic tick();
        @(posedge clk);
        #1;
        prev_x = int'(x);
        prev_y = int'(y);
        if (x == 10'd799) begin
            x = 10'd0;
            y = (y == 10'd524) ? 10'd0 : y + 10'd1;
        end else begin
            x = x + 10'd1;
        end
    endtask

    // Jump the counter a few positions before (tx,ty) and run up so the pipeline is primed.
    task automatic seek(input int tx, input int ty);
        int idx;
        idx = (ty * 800 + tx + 420000 - 6) % 420000;
        x = 10'(idx % 800);
        y = 10'(idx / 800);
        repeat (6) tick();
    endtask

    function automatic logic [14:0] exp_out(input int px, input int py);
        logic act, hs, vs;
        int   lin;
        act = (px < 640) && (py < 480);
        hs  = !(px >= 656 && px <= 751);
        vs  = !(py >= 490 && py <= 491);
`ifdef FB_PIXEL_DOUBLE_EN
        lin = (py / 2) * 320 + px / 2;
`else
        lin = py * 640 + px;
`endif
        return {act, hs, vs, act ? 12'(lin) : 12'h000};
    endfunction

    task automatic sweep(input int ty, input int rows);
        seek(0, ty);
        for (int i = 0; i < rows * 800; i++) begin
            tick();
            check($sformatf("scan x=%0d y=%0d", prev_x, prev_y),
                  {pix_active, hsync, vsync, pix_data}, exp_out(prev_x, prev_y));
        end
    endtask

    initial begin
        vecs[0]  = '{0,   0,   1'b1, 1'b1, 1'b1, P_0_0};
        vecs[1]  = '{1,   0,   1'b1, 1'b1, 1'b1, P_1_0};
        vecs[2]  = '{639, 0,   1'b1, 1'b1, 1'b1, P_639_0};
        vecs[3]  = '{640, 0,   1'b0, 1'b1, 1'b1, 12'h000};
        vecs[4]  = '{0,   1,   1'b1, 1'b1, 1'b1, P_0_1};
        vecs[5]  = '{100, 100, 1'b1, 1'b1, 1'b1, P_100};
        vecs[6]  = '{639, 479, 1'b1, 1'b1, 1'b1, P_LAST};
        vecs[7]  = '{0,   480, 1'b0, 1'b1, 1'b1, 12'h000};
        vecs[8]  = '{655, 10,  1'b0, 1'b1, 1'b1, 12'h000};
        vecs[9]  = '{656, 10,  1'b0, 1'b0, 1'b1, 12'h000};
        vecs[10] = '{751, 10,  1'b0, 1'b0, 1'b1, 12'h000};
        vecs[11] = '{752, 10,  1'b0, 1'b1, 1'b1, 12'h000};
        vecs[12] = '{0,   489, 1'b0, 1'b1, 1'b1, 12'h000};
        vecs[13] = '{0,   490, 1'b0, 1'b1, 1'b0, 12'h000};
        vecs[14] = '{0,   491, 1'b0, 1'b1, 1'b0, 12'h000};
        vecs[15] = '{0,   492, 1'b0, 1'b1, 1'b1, 12'h000};

        for (int a = 0; a < (1 << AW); a++) ram[a] = (a < 307200) ? DW'(a) : '0;

        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        x = 10'd0;
        y = 10'd0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #2;
        check("reset_state", {bus.mem_addr, bus.mem_we, bus.mem_wdata, pix_data, pix_active, hsync, vsync},
              {19'd0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1, 1'b1});
        check("reset_ready", bus.wr_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;

        // Position table
        for (int i = 0; i < 16; i++) begin
            seek(vecs[i].px, vecs[i].py);
            tick();
            check($sformatf("vec%0d x=%0d y=%0d", i, vecs[i].px, vecs[i].py),
                  {pix_active, hsync, vsync, pix_data},
                  {vecs[i].act, vecs[i].hs, vecs[i].vs, vecs[i].pix});
        end

        // Row sweeps across frame wrap, bottom edge and vsync
        sweep(524, 2);
        sweep(0, 2);
        sweep(478, 4);
        sweep(489, 3);

        // Fetch lead near row 479 and at frame wrap
        seek(100, 100);
        x = 10'd798; y = 10'd479;
        tick();
        check("idle_we", bus.mem_we, 1'b0);
        check("idle_hold", bus.mem_addr, HOLD_ADDR);
        bus.wr_valid = 1'b1; bus.wr_addr = 19'd5000; bus.wr_data = 12'h5A5;
        check("push_ready", bus.wr_ready, 1'b1);
        x = 10'd100; y = 10'd100;
        tick();
        bus.wr_valid = 1'b0;
        x = 10'd798; y = 10'd479;
        tick();
        check("wslot_we", bus.mem_we, 1'b1);
        check("wslot_addr", bus.mem_addr, 19'd5000);
        check("wslot_data", bus.mem_wdata, 12'h5A5);
        x = 10'd798; y = 10'd524;
        tick();
        check("wrap_addr", bus.mem_addr, 19'd0);
        check("wrap_we", bus.mem_we, 1'b0);

`ifndef FB_PIXEL_DOUBLE_EN
        // Five writes during active row 100 into a 4-deep FIFO
        seek(590, 100);
        k = 0;
        dq.delete(); oa.delete(); od.delete();
        for (int c = 0; c < 60; c++) begin
            if (k < 5) begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = AW'(1000 + k);
                bus.wr_data  = DW'(12'hA00 + k);
            end else begin
                bus.wr_valid = 1'b0;
            end
            if (x == 10'd594) check("fifo_full", bus.wr_ready, 1'b0);
            acc = bus.wr_valid && bus.wr_ready;
            tick();
            if (acc) k++;
            if (bus.mem_we) begin
                dq.push_back(prev_x);
                oa.push_back(bus.mem_addr);
                od.push_back(bus.mem_wdata);
            end
        end
        check("burst_accepted", k, 5);
        check("burst_writes", dq.size(), 5);
        if (dq.size() > 0) begin
            check("burst_first_x", dq[0], 638);
            check("burst_last_x", dq[dq.size()-1], 642);
        end
        for (int i = 0; i < dq.size(); i++) begin
            check($sformatf("burst_addr%0d", i), oa[i], AW'(1000 + i));
            check($sformatf("burst_data%0d", i), od[i], DW'(12'hA00 + i));
        end
        tick();
        for (int i = 0; i < 5; i++) check($sformatf("burst_ram%0d", i), ram[1000 + i], DW'(12'hA00 + i));
        check("burst_ready", bus.wr_ready, 1'b1);
`endif

        // Out-of-range write is dropped; FIFO keeps flowing
        seek(650, 100);
        bus.wr_valid = 1'b1; bus.wr_addr = 19'd307200; bus.wr_data = 12'hFFF;
        check("oor_ready", bus.wr_ready, 1'b1);
        tick();
        bus.wr_valid = 1'b0;
        nwe = 0;
        repeat (6) begin
            tick();
            if (bus.mem_we) nwe++;
        end
        check("oor_no_we", nwe, 0);
        check("oor_ready_after", bus.wr_ready, 1'b1);
        bus.wr_valid = 1'b1; bus.wr_addr = 19'd2000; bus.wr_data = 12'h123;
        tick();
        bus.wr_valid = 1'b0;
        found = 0;
        repeat (4) begin
            tick();
            if (bus.mem_we && bus.mem_addr == 19'd2000 && bus.mem_wdata == 12'h123) found++;
        end
        check("after_oor_write", found, 1);

        // Reset mid-frame with queued writes
        seek(300, 200);
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = AW'(3000 + i);
            bus.wr_data  = DW'(12'h300 + i);
            tick();
        end
        bus.wr_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst_state", {bus.mem_addr, bus.mem_we, bus.mem_wdata, pix_data, pix_active, hsync, vsync},
              {19'd0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1, 1'b1});
        @(posedge clk);
        #1 rst = 1'b1;
        x = 10'd630; y = 10'd200;
        nwe = 0;
        repeat (30) begin
            tick();
            if (bus.mem_we) nwe++;
        end
        check("no_stale_writes", nwe, 0);
        check("ready_after_rst", bus.wr_ready, 1'b1);
`ifndef FB_PIXEL_DOUBLE_EN
        check("stale_ram", ram[3000], 12'hBB8);
`endif

`ifdef FB_PIXEL_DOUBLE_EN
        // Writer uses odd active slots; pixels repeat across column pairs
        seek(0, 10);
        k = 0;
        dq.delete();
        for (int c = 0; c < 10; c++) begin
            if (k < 3) begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = AW'(70000 + k);
                bus.wr_data  = DW'(12'hC00 + k);
            end else begin
                bus.wr_valid = 1'b0;
            end
            acc = bus.wr_valid && bus.wr_ready;
            tick();
            if (acc) k++;
            if (bus.mem_we) dq.push_back(prev_x);
        end
        check("dbl_writes", dq.size(), 3);
        if (dq.size() == 3) begin
            check("dbl_x0", dq[0], 1);
            check("dbl_x1", dq[1], 3);
            check("dbl_x2", dq[2], 5);
        end
        seek(20, 10);
        for (int j = 0; j < 4; j++) begin
            tick();
            pa = pix_data;
            tick();
            check($sformatf("dbl_pair x=%0d", prev_x), pix_data, pa);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
